// File: rtl/clk_div_cfg_arbiter.sv
// ============================================================================
// Module   : clk_div_cfg_arbiter
// Brief    : Round-robin arbiter that funnels divider-change requests from
//            NUM_REQ requesters into the div/valid/ready reconfiguration
//            handshake of one runtime-configurable integer clock divider.
//            Requests equal to the current divider value are acknowledged
//            without touching the divider, and a hold-off window after each
//            real reconfiguration keeps the output clock from being stalled
//            back to back.
// Options  : CLK_DIV_CFG_ARBITER_TIMEOUT_EN adds a sticky timeout flag
//            (timeout_o / timeout_clr_i) for a divider that never answers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_cfg_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DIV_WIDTH      = 4,
    parameter int DEFAULT_DIV    = 0,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ*DIV_WIDTH-1:0]   req_div_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [DIV_WIDTH-1:0]           div_o,
    output logic                           div_valid_o,
    input  logic                           div_ready_i,
    output logic [DIV_WIDTH-1:0]           cur_div_o,
    output logic                           busy_o
`ifdef CLK_DIV_CFG_ARBITER_TIMEOUT_EN
    ,
    output logic                           timeout_o,
    input  logic                           timeout_clr_i
`endif
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_ho_w  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    localparam logic [DIV_WIDTH-1:0] c_default_div = DIV_WIDTH'(DEFAULT_DIV);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (NUM_REQ < 1) begin : g_chk_num_req
            $error("clk_div_cfg_arbiter: NUM_REQ must be >= 1");
        end
        if (DIV_WIDTH < 1) begin : g_chk_div_width
            $error("clk_div_cfg_arbiter: DIV_WIDTH must be >= 1");
        end
        if ((DEFAULT_DIV < 0) || (DEFAULT_DIV >= (2 ** DIV_WIDTH))) begin : g_chk_default_div
            $error("clk_div_cfg_arbiter: DEFAULT_DIV not representable in DIV_WIDTH bits");
        end
        if (HOLDOFF_CYCLES < 0) begin : g_chk_holdoff
            $error("clk_div_cfg_arbiter: HOLDOFF_CYCLES must be >= 0");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
            $error("clk_div_cfg_arbiter: TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_ptr_w-1:0]    r_idx;       // requester owning the in-flight change
    logic [DIV_WIDTH-1:0]  r_div;       // value presented on div_o
    logic                  r_div_valid;
    logic [DIV_WIDTH-1:0]  r_cur_div;   // last value the divider accepted
    logic                  r_busy;
    logic [c_ho_w-1:0]     r_hold;      // hold-off cycles left after this one

    logic [c_ptr_w-1:0]    w_ptr;       // round-robin search start
    logic                  w_found;
    logic [c_ptr_w-1:0]    w_win;
    logic [DIV_WIDTH-1:0]  w_win_div;
    logic                  w_accept_filt;
    logic                  w_accept_issue;
    logic [NUM_REQ-1:0]    w_req_ready;

    // Index that follows idx in round-robin order.
    function automatic logic [c_ptr_w-1:0] f_next_idx(input logic [c_ptr_w-1:0] idx);
        if (int'(idx) >= (NUM_REQ - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Round-robin search for the first valid requester starting at w_ptr.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid_i[(int'(w_ptr) + i) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = c_ptr_w'((int'(w_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_win_div = req_div_i[int'(w_win) * DIV_WIDTH +: DIV_WIDTH];

    // A request for the value already running is acknowledged on the spot;
    // a divider acceptance acknowledges the latched requester.
    assign w_accept_filt  = (r_state == ST_IDLE) && w_found && (w_win_div == r_cur_div);
    assign w_accept_issue = (r_state == ST_ISSUE) && div_ready_i;

    // Acceptance pulse to exactly one requester, or none.
    always_comb begin
        w_req_ready = '0;
        if (w_accept_issue) begin
            w_req_ready[r_idx] = 1'b1;
        end else if (w_accept_filt) begin
            w_req_ready[w_win] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin pointer; with a single requester it is a constant 0.
    // ------------------------------------------------------------------------
    generate
        if (NUM_REQ == 1) begin : g_ptr_const
            assign w_ptr = '0;
        end else begin : g_ptr_rr
            logic [c_ptr_w-1:0] r_ptr;

            // Pointer moves past whichever requester was just acknowledged.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_ptr <= '0;
                end else if (w_accept_issue) begin
                    r_ptr <= f_next_idx(r_idx);
                end else if (w_accept_filt) begin
                    r_ptr <= f_next_idx(w_win);
                end
            end

            assign w_ptr = r_ptr;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Main controller: grant, divider handshake, hold-off window.
    // ------------------------------------------------------------------------
    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_div       <= c_default_div;
            r_div_valid <= 1'b0;
            r_cur_div   <= c_default_div;
            r_busy      <= 1'b0;
            r_hold      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Only a genuine change goes to the divider.
                    if (w_found && (w_win_div != r_cur_div)) begin
                        r_idx       <= w_win;
                        r_div       <= w_win_div;
                        r_div_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // div_valid_o/div_o stay frozen until the divider takes them.
                    if (div_ready_i) begin
                        r_cur_div   <= r_div;
                        r_div_valid <= 1'b0;
                        if (HOLDOFF_CYCLES == 0) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_hold  <= c_ho_w'(HOLDOFF_CYCLES - 1);
                            r_state <= ST_HOLDOFF;
                        end
                    end
                end

                ST_HOLDOFF: begin
                    // Counter reaching zero marks the last hold-off cycle.
                    if (r_hold == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end

                default: begin
                    r_div_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = w_req_ready;
    assign div_o       = r_div;
    assign div_valid_o = r_div_valid;
    assign cur_div_o   = r_cur_div;
    assign busy_o      = r_busy;

`ifdef CLK_DIV_CFG_ARBITER_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Stuck-handshake watchdog. Only flags the condition; the handshake
    // keeps waiting because the divider must never see valid withdrawn.
    // ------------------------------------------------------------------------
    localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_to_w-1:0] r_to_cnt;    // ISSUE cycles already completed
    logic              r_timeout;

    // Count ISSUE cycles (restarting on every entry) and raise a sticky flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != ST_ISSUE) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != c_to_w'(TIMEOUT_CYCLES)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (timeout_clr_i) begin
                r_timeout <= 1'b0;
            end else if ((r_state == ST_ISSUE) && (r_to_cnt == c_to_w'(TIMEOUT_CYCLES - 1))) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`endif

    // ------------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------------
    // The requester being served must keep its valid up until its ready.
    a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state == ST_ISSUE) |-> req_valid_i[r_idx]);

    // At most one requester is acknowledged per cycle.
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o));

endmodule

`default_nettype wire
